// File: rtl/scaler_pkg.sv
// Shared types and constants for the multi-channel horizontal scaler.
// FRAC derives from the fixed-point unit; LAT is the de_i to de_o depth.
package scaler_pkg;

    typedef enum logic {
        SCL_LINEAR  = 1'b0,
        SCL_NEAREST = 1'b1
    } mode_e;

    localparam int LAT = 3;

    function automatic int frac_bits(input int pixel_step);
        return $clog2(pixel_step);
    endfunction

endpackage

// File: rtl/scaler_h_mc_if.sv
// Video stream bundle: packed pixel plus de/hs/vs timing strobes.
// master drives the stream, slave consumes it.
interface scaler_h_mc_if #(
    parameter int W = 24
);
    logic [W-1:0] pix;
    logic         de;
    logic         hs;
    logic         vs;

    modport master (output pix, de, hs, vs);
    modport slave  (input  pix, de, hs, vs);
endinterface

// File: rtl/scaler_h_mc_mac.sv
// One channel of the 2-tap blend: S1 multiply, S2 add/round/saturate.
// Latency 2 clk; no backpressure, registers load only on their stage enable.
module scaler_h_mc_mac
    import scaler_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int COE_WIDTH   = 8,
    parameter int PIXEL_STEP  = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_mul,
    input  logic                   en_add,
    input  logic [PIXEL_WIDTH-1:0] cur,
    input  logic [PIXEL_WIDTH-1:0] prev,
    input  logic [COE_WIDTH-1:0]   coe_cur,
    input  logic [COE_WIDTH-1:0]   coe_prev,
    output logic [PIXEL_WIDTH-1:0] res
);
    localparam int FRAC = frac_bits(PIXEL_STEP);
    localparam int P_W  = PIXEL_WIDTH + COE_WIDTH;
    localparam int S_W  = P_W + 1;
    localparam logic [S_W-1:0] ROUND   = S_W'(PIXEL_STEP / 2);
    localparam logic [S_W-1:0] PIX_MAX = S_W'((2 ** PIXEL_WIDTH) - 1);

    logic [P_W-1:0] prod_c;
    logic [P_W-1:0] prod_p;
    logic [S_W-1:0] sum;
    logic [S_W-1:0] scaled;

    assign sum    = S_W'(prod_c) + S_W'(prod_p) + ROUND;
    assign scaled = sum >> FRAC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_c <= '0;
            prod_p <= '0;
            res    <= '0;
        end else begin
            if (en_mul) begin
                prod_c <= P_W'(cur)  * P_W'(coe_cur);
                prod_p <= P_W'(prev) * P_W'(coe_prev);
            end
            // Weights sum to PIXEL_STEP so overflow is impossible; clamp anyway.
            if (en_add) begin
                res <= (scaled > PIX_MAX) ? PIX_MAX[PIXEL_WIDTH-1:0] : scaled[PIXEL_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/scaler_h_mc.sv
// Multi-channel horizontal downscaler (linear or nearest), ratio step/PIXEL_STEP >= 1.
// Latency 3 clk de_i->de_o; pure streaming, no backpressure, <=1 output per input.
module scaler_h_mc
    import scaler_pkg::*;
#(
    parameter int CH          = 3,
    parameter int PIXEL_WIDTH = 8,
    parameter int PIXEL_STEP  = 128,
    parameter int COE_WIDTH   = 8,
    parameter int LINE_W_MAX  = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  scale_step_h,
    input  logic                         mode_i,
    scaler_h_mc_if.slave                 vin,
    scaler_h_mc_if.master                vout,
    output logic [$clog2(LINE_W_MAX):0]  out_width_o
);
    localparam int FRAC  = frac_bits(PIXEL_STEP);
    localparam int IDX_W = $clog2(LINE_W_MAX) + 1;
    localparam int TGT_W = IDX_W + FRAC;
    localparam int PIX_W = CH * PIXEL_WIDTH;
    localparam logic [COE_WIDTH-1:0] COE_ONE = COE_WIDTH'(PIXEL_STEP);

    logic [15:0]      step_q;
    mode_e            mode_q;
    logic             line_act;
    logic [TGT_W-1:0] tgt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] out_cnt;
    logic [PIX_W-1:0] prev;

    logic [IDX_W-1:0] tgt_int;
    logic [FRAC-1:0]  tgt_frac;
    logic             take, hit_exact, hit_frac, hit;
    logic [COE_WIDTH-1:0] cc, cp;

    logic             s0_vld, s1_vld, de_q;
    logic [PIX_W-1:0] s0_cur, s0_prev;
    logic [COE_WIDTH-1:0] s0_cc, s0_cp;
    logic [LAT-1:0]   hs_d, vs_d;
    logic [PIX_W-1:0] res;

    // Ratio and mode only move during vertical blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 16'(PIXEL_STEP);
            mode_q <= SCL_LINEAR;
        end else if (vin.vs) begin
            step_q <= (scale_step_h < 16'(PIXEL_STEP)) ? 16'(PIXEL_STEP) : scale_step_h;
            mode_q <= mode_e'(mode_i);
        end
    end

    assign tgt_int   = tgt[TGT_W-1:FRAC];
    assign tgt_frac  = tgt[FRAC-1:0];
    assign take      = vin.de && line_act && !vin.hs;
    assign hit_exact = (tgt == {idx, {FRAC{1'b0}}});
    assign hit_frac  = (idx != '0) && (tgt_int == idx - IDX_W'(1)) && (tgt_frac != '0);
    assign hit       = take && (hit_exact || hit_frac);

    always_comb begin
        cc = COE_ONE;
        cp = '0;
        if (!hit_exact) begin
            if (mode_q == SCL_LINEAR) begin
                cc = COE_WIDTH'(tgt_frac);
                cp = COE_ONE - COE_WIDTH'(tgt_frac);
            end else if (tgt_frac < FRAC'(PIXEL_STEP / 2)) begin
                cc = '0;
                cp = COE_ONE;
            end
        end
    end

    // line_act keeps a mid-line reset from emitting until the next hs_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_act    <= 1'b0;
            tgt         <= '0;
            idx         <= '0;
            out_cnt     <= '0;
            out_width_o <= '0;
            prev        <= '0;
        end else if (vin.hs) begin
            line_act    <= 1'b1;
            tgt         <= '0;
            idx         <= '0;
            out_width_o <= out_cnt;
            out_cnt     <= '0;
        end else if (take) begin
            idx  <= idx + IDX_W'(1);
            prev <= vin.pix;
            if (hit) begin
                tgt     <= tgt + TGT_W'(step_q);
                out_cnt <= out_cnt + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld  <= 1'b0;
            s1_vld  <= 1'b0;
            de_q    <= 1'b0;
            s0_cur  <= '0;
            s0_prev <= '0;
            s0_cc   <= '0;
            s0_cp   <= '0;
            hs_d    <= '0;
            vs_d    <= '0;
        end else begin
            s0_vld <= hit;
            s1_vld <= s0_vld;
            de_q   <= s1_vld;
            hs_d   <= {hs_d[LAT-2:0], vin.hs};
            vs_d   <= {vs_d[LAT-2:0], vin.vs};
            if (hit) begin
                s0_cur  <= vin.pix;
                s0_prev <= prev;
                s0_cc   <= cc;
                s0_cp   <= cp;
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        scaler_h_mc_mac #(
            .PIXEL_WIDTH (PIXEL_WIDTH),
            .COE_WIDTH   (COE_WIDTH),
            .PIXEL_STEP  (PIXEL_STEP)
        ) u_mac (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_mul   (s0_vld),
            .en_add   (s1_vld),
            .cur      (s0_cur[c*PIXEL_WIDTH +: PIXEL_WIDTH]),
            .prev     (s0_prev[c*PIXEL_WIDTH +: PIXEL_WIDTH]),
            .coe_cur  (s0_cc),
            .coe_prev (s0_cp),
            .res      (res[c*PIXEL_WIDTH +: PIXEL_WIDTH])
        );
    end

    assign vout.pix = res;
    assign vout.de  = de_q;
    assign vout.hs  = hs_d[LAT-1];
    assign vout.vs  = vs_d[LAT-1];

endmodule

// File: tb/tb_scaler_h_mc.sv
// Randomized and directed line stimulus against a target-list reference model.
module tb_scaler_h_mc;
    import scaler_pkg::*;

    localparam int CH = 3;
    localparam int PW = 8;
    localparam int PS = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] scale_step_h = 16'd128;
    logic        mode_i = 1'b0;
    logic [12:0] out_width_o;

    scaler_h_mc_if #(.W(CH*PW)) vin ();
    scaler_h_mc_if #(.W(CH*PW)) vout ();

    scaler_h_mc #(
        .CH(CH), .PIXEL_WIDTH(PW), .PIXEL_STEP(PS), .COE_WIDTH(8), .LINE_W_MAX(4096)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scale_step_h (scale_step_h),
        .mode_i       (mode_i),
        .vin          (vin),
        .vout         (vout),
        .out_width_o  (out_width_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int rst_done = 0;
    int cur_step = PS;
    int cur_mode = 0;
    int last_w = 0;

    logic [23:0] line_pix[$];
    int          in_cyc[$];
    logic [23:0] got_pix[$];
    int          got_cyc[$];
    logic [23:0] exp_pix[$];
    int          exp_src[$];
    bit          hist_hs[65536];
    bit          hist_vs[65536];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        hist_hs[cyc & 16'hFFFF] = vin.hs;
        hist_vs[cyc & 16'hFFFF] = vin.vs;
        if (rst_n && vout.de) begin
            got_pix.push_back(vout.pix);
            got_cyc.push_back(cyc);
        end
        if (rst_n && cyc >= rst_done + 4) begin
            chk("hs_o_delay", 32'(vout.hs), 32'(hist_hs[(cyc - 3) & 16'hFFFF]));
            chk("vs_o_delay", 32'(vout.vs), 32'(hist_vs[(cyc - 3) & 16'hFFFF]));
        end
    end

    function automatic logic [23:0] blend(input logic [23:0] a, input logic [23:0] b,
                                          input int f, input int md);
        logic [23:0] r;
        int pa, pb, v;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            pa = int'(a[c*PW +: PW]);
            pb = int'(b[c*PW +: PW]);
            if (md != 0) v = (f >= PS / 2) ? pb : pa;
            else         v = (pa * (PS - f) + pb * f + PS / 2) / PS;
            if (v > 255) v = 255;
            r[c*PW +: PW] = 8'(v);
        end
        return r;
    endfunction

    // Walk output targets k*step across the line; stop at the first one past the end.
    function automatic void model();
        int st, n, t, i, f;
        exp_pix.delete();
        exp_src.delete();
        st = (cur_step < PS) ? PS : cur_step;
        n  = line_pix.size();
        for (int k = 0; k < 5000; k++) begin
            t = k * st;
            i = t / PS;
            f = t % PS;
            if (f == 0) begin
                if (i >= n) break;
                exp_pix.push_back(line_pix[i]);
                exp_src.push_back(i);
            end else begin
                if (i + 1 >= n) break;
                exp_pix.push_back(blend(line_pix[i], line_pix[i+1], f, cur_mode));
                exp_src.push_back(i + 1);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int step, input int md);
        scale_step_h = 16'(step);
        mode_i       = md[0];
        vin.vs       = 1'b1;
        repeat (3) tick();
        vin.vs   = 1'b0;
        cur_step = step;
        cur_mode = md;
        tick();
    endtask

    function automatic logic [23:0] mk_pix(input int x);
        return {8'd128, 8'(255 - x), 8'(x)};
    endfunction

    // gap < 0 picks a random gap per pixel; chg_at >= 0 alters scale_step_h mid-line.
    task automatic run_line(input int n, input int gap, input int rnd, input int chg_at);
        int g;
        line_pix.delete();
        in_cyc.delete();
        got_pix.delete();
        got_cyc.delete();
        for (int i = 0; i < n; i++)
            line_pix.push_back(rnd != 0 ? 24'($urandom) : mk_pix(i + 1));
        vin.hs  = 1'b1;
        vin.de  = 1'b1;
        vin.pix = 24'($urandom);
        tick();
        vin.hs = 1'b0;
        vin.de = 1'b0;
        chk("out_width", 32'(out_width_o), 32'(last_w));
        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            repeat (g) begin
                vin.de  = 1'b0;
                vin.pix = 24'($urandom);
                tick();
            end
            vin.de  = 1'b1;
            vin.pix = line_pix[i];
            in_cyc.push_back(cyc);
            if (i == chg_at) scale_step_h = 16'd300;
            tick();
        end
        vin.de = 1'b0;
        repeat (6) tick();
        model();
        chk("out_count", 32'(got_pix.size()), 32'(exp_pix.size()));
        for (int k = 0; k < got_pix.size() && k < exp_pix.size(); k++) begin
            chk("pixel", 32'(got_pix[k]), 32'(exp_pix[k]));
            chk("latency", 32'(got_cyc[k]), 32'(in_cyc[exp_src[k]] + LAT));
        end
        last_w = exp_pix.size();
    endtask

    initial begin
        vin.pix = '0;
        vin.de  = 1'b0;
        vin.hs  = 1'b0;
        vin.vs  = 1'b0;
        repeat (2) tick();
        chk("rst_pix", 32'(vout.pix), 32'd0);
        chk("rst_de", 32'(vout.de), 32'd0);
        chk("rst_hs", 32'(vout.hs), 32'd0);
        chk("rst_vs", 32'(vout.vs), 32'd0);
        chk("rst_width", 32'(out_width_o), 32'd0);
        rst_n    = 1'b1;
        rst_done = cyc;
        tick();

        frame(256, 0); run_line(8, 0, 0, -1);
        frame(160, 0); run_line(8, 0, 0, -1);
        frame(160, 1); run_line(8, 0, 0, -1);
        frame(100, 0); run_line(8, 0, 0, -1);
        frame(256, 0); run_line(8, 1, 0, -1);
        run_line(8, 3, 0, -1);
        run_line(8, 0, 0, 3);
        run_line(8, 0, 0, -1);
        frame(int'(scale_step_h), 0); run_line(8, 0, 0, -1);
        run_line(0, 0, 0, -1);
        run_line(8, 0, 0, -1);

        // Reset in the middle of a line, then keep feeding pixels without hs_i.
        frame(192, 0);
        vin.hs = 1'b1;
        tick();
        vin.hs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vin.de  = 1'b1;
            vin.pix = mk_pix(i + 1);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_pix", 32'(vout.pix), 32'd0);
        chk("midrst_de", 32'(vout.de), 32'd0);
        chk("midrst_width", 32'(out_width_o), 32'd0);
        tick();
        rst_n    = 1'b1;
        rst_done = cyc;
        got_pix.delete();
        got_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            vin.pix = mk_pix(i + 10);
            tick();
        end
        vin.de = 1'b0;
        repeat (6) tick();
        chk("idle_after_rst", 32'(got_pix.size()), 32'd0);
        last_w   = 0;
        cur_step = PS;
        cur_mode = 0;
        run_line(8, 0, 0, -1);

        frame(192, 0); run_line(8, 0, 0, -1);
        for (int r = 0; r < 14; r++) begin
            frame(int'($urandom_range(90, 600)), int'($urandom_range(0, 1)));
            run_line(int'($urandom_range(1, 40)), -1, 1, -1);
        end
        run_line(3, 0, 1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
